mclr5_lsu: RTL and testbench
============================

# mclr5_lsu

Load/store unit directly downstream of the MCLR5 ALU. Consumes the ALU's load/store request, effective address and store data, runs one transaction on the data-memory bus, and returns sign/zero-extended load data to the ALU's load-data input. Stalls the issuing pipeline slot until the transaction completes, times out, or is rejected.

## Interface
- TIMEOUT_CYCLES, 255: max cycles to wait for MEM_ACK after MEM_REQ rises (1..255, 8-bit counter)
- CORE_CLK  in  1  core clock, all logic on rising edge
- RST_n  in  1  synchronous active-low reset
- LOAD_REQ  in  1  load request from ALU, level, held while STALL high
- STORE_REQ  in  1  store request from ALU, level, held while STALL high
- FUNCT3  in  3  OPCODE[14:12] of the requesting instruction
- LOAD_STORE_ADDRESS  in  32  effective byte address
- STORE_DATA  in  32  store data (RS2)
- LOAD_DATA  out  32  extended load result to ALU
- STALL  out  1  hold issuing slot
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  qualifies DONE: access failed
- MEM_REQ  out  1  bus request, level
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  32  word address, bits [1:0] always 0
- MEM_BE  out  4  byte enables, bit n = byte lane n
- MEM_WDATA  out  32  write data, lane-replicated
- MEM_RDATA  in  32  read data, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle transfer acknowledge

## Operation
- States: IDLE, BUS, DONE. Reset: IDLE; LOAD_DATA=0, DONE=0, ERR=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_BE=0, MEM_WDATA=0, timeout counter=0.
- IDLE: on LOAD_REQ or STORE_REQ, capture FUNCT3, address, store data, direction. Both high: load wins, store ignored. Go BUS (or DONE with ERR, see Configuration).
- Sizes: FUNCT3 000 byte, 001 half, 010 word; loads also 100 LBU, 101 LHU. Other codes: no bus cycle, DONE with ERR=1.
- Little-endian lanes: byte -> BE=0001<<addr[1:0]; half -> 0011<<{addr[1],0}; word -> 1111. MEM_WDATA: byte replicated x4, half x2, word as-is. MEM_BE for loads is the same lane mask.
- BUS: MEM_REQ held with stable ADDR/BE/WE/WDATA until MEM_ACK. On ACK: load selects lane from MEM_RDATA, sign-extends (000,001) or zero-extends (100,101), registers into LOAD_DATA; store leaves LOAD_DATA unchanged; go DONE, MEM_REQ drops.
- Timeout: counter clears on entering BUS, increments each BUS cycle without ACK; reaching TIMEOUT_CYCLES -> drop MEM_REQ, LOAD_DATA=0 for loads, DONE with ERR=1.
- DONE: DONE=1 for exactly one cycle, ERR valid; requests ignored; next state IDLE.
- MEM_ACK outside BUS ignored. Reset mid-transaction: IDLE next edge, MEM_REQ low, late ACK ignored.

## Timing
- STALL = (state==BUS) | (state==IDLE & (LOAD_REQ|STORE_REQ)), combinational; low in DONE cycle so the slot advances at end of DONE cycle with LOAD_DATA valid.
- Request seen cycle N -> MEM_REQ high N+1. ACK in cycle M (M>=N+1, ACK in first MEM_REQ cycle allowed) -> DONE high M+1. Minimum request-to-DONE: 2 cycles.
- Timeout: MEM_REQ high exactly TIMEOUT_CYCLES cycles, DONE/ERR the following cycle.
- Back-to-back: new request in cycle after DONE accepted immediately (IDLE).

## Configuration
- MCLR5_LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no bus cycle, DONE with ERR=1 in cycle N+1, LOAD_DATA=0 for loads.
- Undefined: misaligned low bits ignored (half uses addr[1] only, word uses none); access runs normally, never ERR from alignment.

## Test plan
- LW addr 0x100, ACK same cycle MEM_REQ rises, RDATA 0xDEADBEEF -> MEM_ADDR 0x100, BE 1111, DONE at N+2, LOAD_DATA 0xDEADBEEF, ERR=0.
- LB addr 0x103 RDATA 0x80FF_FF7F -> BE 1000, LOAD_DATA 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201 STORE_DATA 0x0000_00A5 -> MEM_WE=1, BE 0010, WDATA 0xA5A5A5A5, LOAD_DATA unchanged.
- TIMEOUT_CYCLES=4, no ACK -> MEM_REQ high 4 cycles, then DONE=1 ERR=1, LOAD_DATA 0; late ACK ignored.
- LW addr 0x102: with macro -> DONE/ERR at N+1, MEM_REQ never high; without -> bus read at 0x100, ERR=0.
- RST_n low while in BUS -> MEM_REQ 0, DONE 0 next edge; LOAD_REQ and STORE_REQ both high -> read issued, MEM_WE=0.

Source files
------------

// File: rtl/mclr5_lsu_if.sv
// Data-memory bus between the MCLR5 load/store unit (master) and data memory (slave).
// One level request held until a single-cycle acknowledge.
interface mclr5_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mclr5_lsu.sv
// MCLR5 load/store unit: one bus transaction per ALU request, with timeout and extension.
// Define MCLR5_LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses without a bus cycle.
module mclr5_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [2:0]        funct3,
  input  logic [31:0]       load_store_address,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  mclr5_lsu_if.master       mem
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req;
  logic        size_ok;
  logic        misalign;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] lane_data;
  logic [31:0] ext_data;

  // Request decode: lane offset, byte enables and replicated write data.
  always_comb begin
    req = load_req | store_req;
    case (funct3)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = load_req;
      default:                size_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        lane  = load_store_address[1:0];
        be    = 4'b0001 << load_store_address[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane  = {load_store_address[1], 1'b0};
        be    = 4'b0011 << {load_store_address[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        lane  = 2'b00;
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
`ifdef MCLR5_LSU_MISALIGN_TRAP_EN
    misalign = ((funct3[1:0] == 2'b01) && load_store_address[0]) ||
               ((funct3[1:0] == 2'b10) && (load_store_address[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    lane_data = mem.mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  ext_data = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  ext_data = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b100:  ext_data = {24'b0, lane_data[7:0]};
      3'b101:  ext_data = {16'b0, lane_data[15:0]};
      default: ext_data = lane_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    is_load_d   = is_load_q;
    lane_d      = lane_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    tmo_d       = tmo_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          funct3_d  = funct3;
          is_load_d = load_req;
          if (!size_ok || misalign) begin
            err_d   = 1'b1;
            state_d = StDone;
            if (load_req) load_data_d = '0;
          end else begin
            err_d   = 1'b0;
            lane_d  = lane;
            we_d    = ~load_req;
            addr_d  = {load_store_address[31:2], 2'b00};
            be_d    = be;
            wdata_d = wdata;
            tmo_d   = '0;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        if (mem.mem_ack) begin
          if (is_load_q) load_data_d = ext_data;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (tmo_q == TmoLast) begin
          if (is_load_q) load_data_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      funct3_q    <= '0;
      is_load_q   <= 1'b0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      tmo_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      is_load_q   <= is_load_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  // Stall drops in the DONE cycle so the slot advances with load_data already valid.
  assign stall         = (state_q == StBus) || ((state_q == StIdle) && req);
  assign done          = (state_q == StDone);
  assign err           = done & err_q;
  assign load_data     = load_data_q;
  assign mem.mem_req   = (state_q == StBus);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mclr5_lsu.sv
// Randomized bench for mclr5_lsu against a byte-lane reference model and a latency model.
// Responds to the memory bus with a chosen acknowledge delay or none (timeout).
module tb_mclr5_lsu;

  localparam int Tmo = 4;

  logic        core_clk = 1'b0;
  logic        rst_n;
  logic        load_req, store_req;
  logic [2:0]  funct3;
  logic [31:0] load_store_address, store_data;
  logic [31:0] load_data;
  logic        stall, done, err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_ld;
  bit          ld_known;

  mclr5_lsu_if mem_bus ();

  mclr5_lsu #(.TIMEOUT_CYCLES(Tmo)) dut (
    .core_clk           (core_clk),
    .rst_n              (rst_n),
    .load_req           (load_req),
    .store_req          (store_req),
    .funct3             (funct3),
    .load_store_address (load_store_address),
    .store_data         (store_data),
    .load_data          (load_data),
    .stall              (stall),
    .done               (done),
    .err                (err),
    .mem                (mem_bus.master)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit legal(input bit ld, input logic [2:0] f);
    return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (ld && (f == 3'd4 || f == 3'd5));
  endfunction

  function automatic bit trap(input logic [2:0] f, input logic [31:0] a);
`ifdef MCLR5_LSU_MISALIGN_TRAP_EN
    return (a % nbytes(f)) != 0;
`else
    return (f != f) || (a != a);
`endif
  endfunction

  // Byte offset in the word actually used: natural alignment truncates low address bits.
  function automatic int offset(input logic [2:0] f, input logic [31:0] a);
    int nb;
    nb = nbytes(f);
    return int'(a % 4) / nb * nb;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int nb;
    nb = nbytes(f);
    return 4'(((1 << nb) - 1) << offset(f, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] sd);
    logic [31:0] w;
    int nb;
    nb = nbytes(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint r, v, span;
    int nb;
    nb   = nbytes(f);
    span = longint'(1) << (8 * nb);
    r    = longint'({32'b0, rd});
    v    = (r >> (8 * offset(f, a))) % span;
    if (!f[2] && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One request from cycle N; delay = ack offset from first mem_req cycle (>= Tmo: no ack).
  task automatic run_txn(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] sd, input int delay, input logic [31:0] rd);
    bit is_ld, ok, exp_err, seen_done;
    int exp_done, exp_req, req_cycles;
    is_ld      = ld;
    ok         = legal(is_ld, f) && !trap(f, a);
    exp_done   = !ok ? 1 : (delay < Tmo ? delay + 2 : Tmo + 1);
    exp_err    = !ok || delay >= Tmo;
    exp_req    = !ok ? 0 : (delay + 1 < Tmo ? delay + 1 : Tmo);
    req_cycles = 0;
    seen_done  = 1'b0;
    @(posedge core_clk); #1;
    load_req = ld; store_req = st; funct3 = f;
    load_store_address = a; store_data = sd; mem_bus.mem_ack = 1'b0;
    #1 check("stall_on_request", stall, 1);
    for (int c = 1; c <= Tmo + 8 && !seen_done; c++) begin
      @(posedge core_clk); #1;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = $urandom;
      if (mem_bus.mem_req) begin
        req_cycles++;
        check("mem_addr", mem_bus.mem_addr, a & 32'hFFFF_FFFC);
        check("mem_be", mem_bus.mem_be, model_be(f, a));
        check("mem_we", mem_bus.mem_we, !is_ld);
        check("stall_bus", stall, 1);
        if (!is_ld) check("mem_wdata", mem_bus.mem_wdata, model_wdata(f, sd));
        if (c == delay + 1) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = rd;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", c, exp_done);
        check("err", err, exp_err);
        check("stall_in_done", stall, 0);
        if (is_ld) begin
          if (!legal(is_ld, f)) ld_known = 1'b0;
          else begin
            exp_ld   = exp_err ? 32'h0 : model_load(f, a, rd);
            ld_known = 1'b1;
          end
        end
        if (ld_known) check("load_data", load_data, exp_ld);
      end
    end
    if (!seen_done) check("done_seen", 0, 1);
    check("mem_req_cycles", req_cycles, exp_req);
  endtask

  task automatic idle(input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      @(posedge core_clk); #1;
      check("idle_done", done, 0);
      check("idle_mem_req", mem_bus.mem_req, 0);
      if (ld_known) check("idle_load_data", load_data, exp_ld);
      load_req = 1'b0; store_req = 1'b0;
      mem_bus.mem_ack   = stray_ack;
      mem_bus.mem_rdata = $urandom;
    end
    @(posedge core_clk); #1;
    mem_bus.mem_ack = 1'b0;
    check("idle_after_stray", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    bit          ld, st;
    int          d;

    rst_n = 1'b0; load_req = 1'b0; store_req = 1'b0; funct3 = '0;
    load_store_address = '0; store_data = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    exp_ld = '0; ld_known = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    check("rst_load_data", load_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_req", mem_bus.mem_req, 0);
    check("rst_mem_we", mem_bus.mem_we, 0);
    check("rst_mem_addr", mem_bus.mem_addr, 0);
    check("rst_mem_be", mem_bus.mem_be, 0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;

    run_txn(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    check("lw_plan", load_data, 32'hDEAD_BEEF);
    run_txn(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_FF7F);
    check("lb_plan", load_data, 32'hFFFF_FF80);
    run_txn(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF_FF7F);
    check("lbu_plan", load_data, 32'h0000_0080);
    run_txn(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_FF7F);
    check("lh_plan", load_data, 32'hFFFF_80FF);
    run_txn(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 1, 32'h0);
    check("sb_keeps_load_data", load_data, 32'hFFFF_80FF);
    run_txn(1, 0, 3'b010, 32'h300, 32'h0, Tmo, 32'h1234_5678);
    check("timeout_load_data", load_data, 32'h0);
    idle(2, 1'b1);
    run_txn(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h1122_3344);
    run_txn(1, 1, 3'b010, 32'h404, 32'h5555_5555, 0, 32'hCAFE_F00D);
    run_txn(0, 1, 3'b111, 32'h500, 32'h1, 0, 32'h0);

    // Reset in the middle of a bus cycle, then a late acknowledge.
    @(posedge core_clk); #1;
    load_req = 1'b1; store_req = 1'b0; funct3 = 3'b010; load_store_address = 32'h40;
    @(posedge core_clk); #1;
    check("mid_rst_req_up", mem_bus.mem_req, 1);
    @(posedge core_clk); #1;
    rst_n = 1'b0;
    @(posedge core_clk); #1;
    check("mid_rst_mem_req", mem_bus.mem_req, 0);
    check("mid_rst_done", done, 0);
    rst_n = 1'b1; load_req = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
    exp_ld = '0; ld_known = 1'b1;
    @(posedge core_clk); #1;
    mem_bus.mem_ack = 1'b0;
    check("late_ack_done", done, 0);
    check("late_ack_load_data", load_data, 0);

    for (int i = 0; i < 300; i++) begin
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      f  = 3'($urandom);
      a  = $urandom;
      d  = ($urandom_range(0, 9) < 2) ? Tmo + int'($urandom_range(0, 2))
                                      : int'($urandom_range(0, Tmo - 1));
      run_txn(ld, st, f, a, $urandom, d, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
